// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types, plus the dump sequencer's state encoding and constants.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] dump_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REQ,
        WAIT,
        SHOW
    } dump_state_t;

    localparam word_t      DUMP_ERR_WORD  = 32'hBAD0BAD0;
    localparam dump_addr_t DUMP_ADDR_MASK = 16'hFFFC;
    localparam dump_addr_t DUMP_STRIDE    = 16'd4;

    // The dump window covers the low 64 KiB of the system address space.
    function automatic word_t dump_bus_addr(input dump_addr_t a);
        return {16'b0, a};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer + stability filter; one-cycle pulse per accepted press.
// Press to pulse is DEBOUNCE_CYCLES + 3 cycles; releases produce nothing.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
            // Any sample matching the accepted level restarts the stability run.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/halt_dump_ctrl.sv
// Post-halt memory walker: owns the debug read port while halt is high and latches each word.
// Halt to REN 2 cycles, step to REN 1 cycle; a read waits for mem_ready up to TIMEOUT cycles.
module halt_dump_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_PERIOD     = 25000000,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        key_n,
    input  logic        auto_en,
    input  logic [15:0] start_addr,
    input  logic        mem_ready,
    input  word_t       load,
    output logic        REN,
    output word_t       addr,
    output word_t       disp_word,
    output logic [15:0] disp_addr,
    output logic        valid,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(AUTO_PERIOD + 1);

    dump_state_t   state_q;
    logic          ren_q;
    dump_addr_t    cur_q;
    word_t         disp_word_q;
    dump_addr_t    disp_addr_q;
    logic          valid_q;
    logic          err_q;
    logic [TW-1:0] tmo_q;
    logic [AW-1:0] auto_cnt_q;
    logic          auto_en_q;

    logic key_press;
    logic auto_tc;
    logic step;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (CLK),
        .rst_n_i(nRST),
        .key_n_i(key_n),
        .press_o(key_press)
    );

    // A mode flip is held off for a cycle so the timer restarts from zero.
    always_comb begin
        auto_tc = auto_en && auto_en_q && (auto_cnt_q == AW'(AUTO_PERIOD - 1));
        step    = auto_en ? auto_tc : key_press;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            ren_q       <= 1'b0;
            cur_q       <= '0;
            disp_word_q <= '0;
            disp_addr_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            auto_cnt_q  <= '0;
            auto_en_q   <= 1'b0;
        end else begin
            auto_en_q <= auto_en;
            if (!halt) begin
                state_q <= IDLE;
                ren_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cur_q   <= start_addr & DUMP_ADDR_MASK;
                        state_q <= ARM;
                    end
                    ARM: begin
                        ren_q   <= 1'b1;
                        state_q <= REQ;
                    end
                    REQ: begin
                        tmo_q   <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        // mem_ready wins over a timeout landing in the same cycle.
                        if (mem_ready) begin
                            disp_word_q <= load;
                            disp_addr_q <= cur_q;
                            valid_q     <= 1'b1;
                            err_q       <= 1'b0;
                            ren_q       <= 1'b0;
                            auto_cnt_q  <= '0;
                            state_q     <= SHOW;
                        end else if (tmo_q == TW'(TIMEOUT)) begin
                            disp_word_q <= DUMP_ERR_WORD;
                            disp_addr_q <= cur_q;
                            valid_q     <= 1'b0;
                            err_q       <= 1'b1;
                            ren_q       <= 1'b0;
                            auto_cnt_q  <= '0;
                            state_q     <= SHOW;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    SHOW: begin
                        if (step) begin
                            cur_q   <= cur_q + DUMP_STRIDE;
                            ren_q   <= 1'b1;
                            state_q <= REQ;
                        end else if (auto_en && auto_en_q) begin
                            auto_cnt_q <= auto_cnt_q + AW'(1);
                        end else begin
                            auto_cnt_q <= '0;
                        end
                    end
                    default: begin
                        ren_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign REN       = ren_q;
    assign addr      = dump_bus_addr(cur_q);
    assign disp_word = disp_word_q;
    assign disp_addr = disp_addr_q;
    assign valid     = valid_q;
    assign err       = err_q;

endmodule
